// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the EX-stage multiply/divide unit.
//   op_e     : encodings of the op_i port (MULT, MULTU, DIV, DIVU)
//   state_e  : iterative mul/div sequencer states
//   MULDIV_WIDTH : default operand width
package cpu_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit (EX stage).
// One WIDTH-step shift-add multiply or restoring divide per accepted start.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i, op_i, data1_i, data2_i : operation request, sampled in IDLE only
//   flush_i                          : abort in-flight op, also blocks a start
//   busy_o                           : high in CALC and FIX
//   done_o                           : one-cycle pulse when hi_o/lo_o update
//   hi_o / lo_o                      : product high/low, or remainder/quotient
//   div_zero_o                       : last completed op divided by zero
module iter_muldiv
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]     b_q, b_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d, done_q, done_d;

  // Operand capture: magnitudes of signed operands.
  logic               signed_in, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_in = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg     = signed_in & data1_i[WIDTH-1];
  assign b_neg     = signed_in & data2_i[WIDTH-1];
  assign mag_a     = a_neg ? -data1_i : data1_i;
  assign mag_b     = b_neg ? -data2_i : data2_i;

  // Multiply step: add multiplicand into the upper half when the multiplier
  // LSB (acc bit 0) is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;

  assign mul_sum  = acc_q[2*WIDTH:WIDTH] + b_q;
  assign mul_next = acc_q[0] ? {1'b0, mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH:1]};

  // Restoring divide step: shift left, subtract divisor from the partial
  // remainder when it fits, and shift the quotient bit into the LSB.
  logic [2*WIDTH:0]   div_shl, div_next;
  logic               div_fits;

  assign div_shl  = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_fits = div_shl[2*WIDTH:WIDTH] >= b_q;
  assign div_next = div_fits ? {div_shl[2*WIDTH:WIDTH] - b_q, div_shl[WIDTH-1:1], 1'b1}
                             : div_shl;

  // Sign fix-up of the finished magnitudes.
  logic               is_mul_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign prod_fix = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = ST_CALC;
          op_d     = op_e'(op_i);
          cnt_d    = '0;
          acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
          b_d      = {1'b0, mag_b};
          neg_lo_d = a_neg ^ b_neg;
          // Remainder follows the dividend; product sign uses both.
          neg_hi_d = op_i[1] ? a_neg : (a_neg ^ b_neg);
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_mul_q ? mul_next : div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
            dz_d = 1'b0;
          end else if (b_q == '0) begin
            // With a zero divisor every trial subtract succeeds, so the
            // remainder ends as |dividend|; re-applying the dividend sign
            // recovers data1_i exactly as sampled.
            hi_d = rem_fix;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
            dz_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed + scoreboard bench for iter_muldiv.
module tb_iter_muldiv;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_e0 = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  exp_t sb[$];

  iter_muldiv #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_zero_o(div_zero_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    exp_t e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          e.hi = r[31:0]; e.lo = q[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Drive a start for one edge (E0); optionally push the expected result.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input exp_t e);
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    last_e0 = cyc;
    if (push) sb.push_back(e);
  endtask

  // Wait (bounded) for done_o, then check latency, busy and the result.
  task automatic wait_done(input string tag);
    int n = 0;
    int busy_bad = 0;
    bit seen = 0;
    exp_t e;
    while (n < 60) begin
      @(negedge clk_i);
      n++;
      if (done_o) begin seen = 1; break; end
      if (!busy_o) busy_bad++;
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(cyc - last_e0 + 1), 32'd34);
    chk({tag, ".busy_during"}, 32'(busy_bad), 32'd0);
    chk({tag, ".busy_at_done"}, 32'(busy_o), 32'd0);
    chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".hi"}, hi_o, e.hi);
      chk({tag, ".lo"}, lo_o, e.lo);
      chk({tag, ".dz"}, 32'(div_zero_o), 32'(e.dz));
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  initial begin
    exp_t e;
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.hi", hi_o, 32'd0);
    chk("rst.lo", lo_o, 32'd0);
    chk("rst.dz", 32'(div_zero_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: MULTU max x max
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0});
    wait_done("multu_max");
    // 2: signed multiply and divide
    launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0});
    wait_done("mult_neg");
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
    wait_done("div_neg");
    // 3: divide by zero then a normal DIVU clears the flag
    launch(2'b11, 32'd100, 32'd0, 1, '{hi: 32'd100, lo: 32'hFFFF_FFFF, dz: 1'b1});
    wait_done("divu_zero");
    launch(2'b11, 32'd100, 32'd7, 1, '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    wait_done("divu_7");
    launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1, '{hi: 32'hFFFF_FFF9, lo: 32'hFFFF_FFFF, dz: 1'b1});
    wait_done("div_zero_neg");
    // 4: overflow case wraps
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, '{hi: 32'h0, lo: 32'h8000_0000, dz: 1'b0});
    wait_done("div_ovf");

    // 5a: start while busy is ignored
    launch(2'b00, 32'd123456, 32'hFFFF_FF00, 1, model(2'b00, 32'd123456, 32'hFFFF_FF00));
    repeat (9) @(posedge clk_i);
    #1;
    start_i = 1'b1; op_i = 2'b11; data1_i = 32'd99; data2_i = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("start_ignored");

    // 5b: flush mid-CALC
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, '0);
    repeat (4) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush.busy", 32'(busy_o), 32'd0);
    chk("flush.done", 32'(done_o), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("flush.no_done", 32'(dones), 32'd0);
    chk("flush.hi_kept", hi_o, last_hi);
    chk("flush.lo_kept", lo_o, last_lo);

    // flush and start together in IDLE: start refused
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; data1_i = 32'd3; data2_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_start.busy", 32'(busy_o), 32'd0);

    // 6: asynchronous reset mid-CALC
    @(posedge clk_i); #1;
    launch(2'b00, 32'd77, 32'd88, 0, '0);
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst.busy", 32'(busy_o), 32'd0);
    chk("arst.done", 32'(done_o), 32'd0);
    chk("arst.hi", hi_o, 32'd0);
    chk("arst.lo", lo_o, 32'd0);
    chk("arst.dz", 32'(div_zero_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // back-to-back: next start is presented in the done cycle
    launch(2'b01, 32'd40000, 32'd50000, 1, '{hi: 32'h0, lo: 32'd2000000000, dz: 1'b0});
    wait_done("b2b_first");
    launch(2'b11, 32'd1000, 32'd33, 1, '{hi: 32'd10, lo: 32'd30, dz: 1'b0});
    wait_done("b2b_second");

    // random operations checked against a behavioural model
    for (int i = 0; i < 12; i++) begin
      rop = 2'(i % 4);
      ra = $urandom;
      rb = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      launch(rop, ra, rb, 1, model(rop, ra, rb));
      wait_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage.
- hi_o or lo_o drives the data2_i leg of the EX result 32-bit 2:1 select. ALU result is on data1_i; select is high for MFHI/MFLO.
- One 32-step shift-add multiply or restoring divide per start. HI/LO stay held until the next completed operation.
- Control stalls the pipeline while busy_o is high.

Parameters:
- WIDTH, 32, operand width. hi_o and lo_o are each WIDTH bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  begin an operation; sampled only in IDLE.
- op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start_i.
- data1_i  input  WIDTH  multiplicand / dividend; sampled with start_i.
- data2_i  input  WIDTH  multiplier / divisor; sampled with start_i.
- flush_i  input  1  abort in-flight operation.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; hi_o/lo_o updated in the same cycle.
- hi_o  output  WIDTH  product[63:32] or remainder.
- lo_o  output  WIDTH  product[31:0] or quotient.
- div_zero_o  output  1  last completed op was a divide by zero; held until next completion.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0; internal counter and accumulators cleared.
- Reset mid-operation: abort immediately; nothing retained.

State machine:
- IDLE -> CALC on edge with start_i=1 and flush_i=0.
  - Latch op and |operands| (magnitudes for signed ops).
  - Latch result-sign flags. Counter=0.
- CALC: one shift-add (mul) or shift-subtract-restore (div) step per edge.
  - counter increments each edge.
  - Leave to FIX after WIDTH steps.
- FIX -> IDLE: apply sign correction and register hi_o/lo_o/div_zero_o. done_o=1 for exactly the following cycle.

Timing and handshake:
- busy_o=1 in CALC and FIX, 0 in IDLE.
- Latency: start edge E0, steps E1..E32, FIX at E33. done_o high and new hi/lo visible in the cycle after E33. That is 34 edges from start edge to result.
- start_i while busy_o=1: ignored.
- start_i in the cycle where done_o=1: accepted (state is IDLE).
- flush_i=1 in CALC/FIX: return to IDLE next edge.
  - No done_o; hi_o/lo_o/div_zero_o keep their old values.
- flush_i and start_i together in IDLE: flush wins; start not accepted.

Arithmetic:
- MULT: 64-bit two's-complement product of signed operands.
- MULTU: unsigned product.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
- DIVU: unsigned quotient and remainder.
- Divisor 0 (DIV or DIVU): full latency still applies.
  - lo_o=0xFFFFFFFF, hi_o=data1_i as sampled (unsigned view), div_zero_o=1.
  - No sign correction.
- Any non-divide-by-zero completion clears div_zero_o.
- Operands are internally WIDTH+1 bits for magnitudes; 2*WIDTH accumulator.

Decomposition:
- Shared package cpu_pkg holds:
  - op_i encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding ST_IDLE, ST_CALC, ST_FIX;
  - MULDIV_WIDTH=32.
- No sub-module; the datapath is a single accumulator shared between mul and div, with sign fix-up inline.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at cycle 0 -> done_o pulse at cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy_o high cycles 1-33.
2. MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100, div_zero_o=1. Then DIVU 100 / 7 -> lo=14, hi=2, div_zero_o=0.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero_o=0.
5. Start MULT; pulse start_i with new operands at cycle 10 -> ignored, original result delivered. Then flush_i at cycle 5 of the next op -> busy_o=0 next cycle, no done_o, hi/lo unchanged.
6. rst_i low mid-CALC, asynchronously -> all outputs 0 without a clock edge. After release, back-to-back ops with start_i held during done_o -> second op accepted, second done_o 34 cycles later.
